// File: rtl/ov7670_capture_if.sv
// ov7670_capture_if
//   Bundles the camera DVP inputs and the captured-pixel outputs of
//   ov7670_capture.
//   slave  : the capture block (receives vsync/href/d, drives the pixel side)
//   master : the camera/consumer side (drives vsync/href/d, observes pixels)
//   Signals:
//     vsync, href, d  camera sync and byte data (launched on PCLK fall)
//     pix_data        RGB565 pixel {first byte, second byte}
//     pix_valid       1-cycle strobe qualifying pix_data/pix_addr/pix_x/pix_y
//     pix_addr        linear frame-buffer address y*H_ACTIVE + x
//     pix_x, pix_y    pixel coordinates
//     sof, eof        1-cycle frame start / frame end pulses
//     size_err        sticky per frame, frame geometry did not match
interface ov7670_capture_if #(
  parameter int ADDR_W = 19
);
  logic              vsync;
  logic              href;
  logic [7:0]        d;
  logic [15:0]       pix_data;
  logic              pix_valid;
  logic [ADDR_W-1:0] pix_addr;
  logic [9:0]        pix_x;
  logic [8:0]        pix_y;
  logic              sof;
  logic              eof;
  logic              size_err;

  modport slave (
    input  vsync, href, d,
    output pix_data, pix_valid, pix_addr, pix_x, pix_y, sof, eof, size_err
  );

  modport master (
    output vsync, href, d,
    input  pix_data, pix_valid, pix_addr, pix_x, pix_y, sof, eof, size_err
  );
endinterface

// File: rtl/ov7670_capture.sv
// ov7670_capture
//   Captures the OV7670 DVP byte stream in RGB565 mode once the camera has
//   been configured. Byte pairs become 16-bit pixels tagged with x/y and a
//   linear frame-buffer address; frame start/end are pulsed and any frame
//   whose geometry differs from H_ACTIVE x V_ACTIVE raises size_err.
//   Ports:
//     clk       camera PCLK, inputs sampled on the rising edge
//     rst_n     asynchronous active-low reset
//     cfg_done  camera configuration complete; low holds the block idle
//     cam       ov7670_capture_if.slave (DVP inputs, pixel outputs)
//
//   state  | meaning
//   IDLE   | camera not configured, nothing captured
//   SYNC   | configured, waiting for vsync falling edge to start a frame
//   ACTIVE | inside a frame, pairing bytes while href is high
module ov7670_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_done,
  ov7670_capture_if.slave     cam
);

  typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;

  localparam logic [9:0] H_L = 10'(H_ACTIVE);
  localparam logic [8:0] V_L = 9'(V_ACTIVE);

  // Input registers (q) followed by a second stage (d_*) that the byte path
  // consumes, and a third stage (e) on the sync lines so that href/vsync edges
  // are detected on the same time base as the bytes they frame.
  logic       vs_q, hr_q, vs_d, hr_d, vs_e, hr_e;
  logic [7:0] d_q, d_d;

  state_t            state;
  logic              phase;
  logic [7:0]        hi_byte;
  logic [9:0]        x_cnt;
  logic [8:0]        y_cnt;
  logic [ADDR_W-1:0] addr_cnt;

  logic       vs_fall, vs_rise, hr_fall, in_range;
  logic [8:0] y_closed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= 1'b0;
      hr_q <= 1'b0;
      d_q  <= 8'd0;
      vs_d <= 1'b0;
      hr_d <= 1'b0;
      d_d  <= 8'd0;
      vs_e <= 1'b0;
      hr_e <= 1'b0;
    end else begin
      vs_q <= cam.vsync;
      hr_q <= cam.href;
      d_q  <= cam.d;
      vs_d <= vs_q;
      hr_d <= hr_q;
      d_d  <= d_q;
      vs_e <= vs_d;
      hr_e <= hr_d;
    end
  end

  always_comb begin
    vs_fall  = vs_e & ~vs_d;
    vs_rise  = vs_d & ~vs_e;
    hr_fall  = hr_e & ~hr_d;
    in_range = (x_cnt < H_L) && (y_cnt < V_L);
    // Row count as it will stand after a line closing in this same cycle,
    // so a vsync rise coincident with the last href fall is judged correctly.
    y_closed = (hr_fall && (x_cnt != 10'd0)) ? y_cnt + 9'd1 : y_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      phase        <= 1'b0;
      hi_byte      <= 8'd0;
      x_cnt        <= 10'd0;
      y_cnt        <= 9'd0;
      addr_cnt     <= '0;
      cam.pix_data  <= 16'd0;
      cam.pix_valid <= 1'b0;
      cam.pix_addr  <= '0;
      cam.pix_x     <= 10'd0;
      cam.pix_y     <= 9'd0;
      cam.sof       <= 1'b0;
      cam.eof       <= 1'b0;
      cam.size_err  <= 1'b0;
    end else begin
      cam.pix_valid <= 1'b0;
      cam.sof       <= 1'b0;
      cam.eof       <= 1'b0;
      if (!cfg_done) begin
        // Abort without eof; the next frame has to be re-acquired at vsync fall.
        state <= IDLE;
        phase <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= SYNC;
          SYNC: begin
            if (vs_fall) begin
              state        <= ACTIVE;
              cam.sof      <= 1'b1;
              cam.size_err <= 1'b0;
              x_cnt        <= 10'd0;
              y_cnt        <= 9'd0;
              addr_cnt     <= '0;
              phase        <= 1'b0;
            end
          end
          ACTIVE: begin
            if (hr_d) begin
              phase <= ~phase;
              if (!phase) begin
                hi_byte <= d_d;
              end else if (in_range) begin
                cam.pix_data  <= {hi_byte, d_d};
                cam.pix_valid <= 1'b1;
                cam.pix_addr  <= addr_cnt;
                cam.pix_x     <= x_cnt;
                cam.pix_y     <= y_cnt;
                x_cnt         <= x_cnt + 10'd1;
                addr_cnt      <= addr_cnt + ADDR_W'(1);
              end else begin
                // Out-of-frame pixel: dropped so addr can never run past the buffer.
                cam.size_err <= 1'b1;
              end
            end
            if (hr_fall) begin
              phase <= 1'b0;
              x_cnt <= 10'd0;
              if (x_cnt != 10'd0) y_cnt <= y_cnt + 9'd1;
              // phase=1 here means an unpaired byte is being discarded.
              if (phase || (x_cnt != H_L)) cam.size_err <= 1'b1;
            end
            if (vs_rise) begin
              state   <= SYNC;
              cam.eof <= 1'b1;
              if (y_closed != V_L) cam.size_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
